telemetry_mon: RTL and testbench

- Receives the eBike TX telemetry stream: serial UART, 8N1, LSB first.
- Decodes each 8-byte telemetry packet into 12-bit battery, current and torque values, each presented with a single-cycle valid strobe.
- Sits directly downstream of the eBike TX pin. Used in the top-level bench as the telemetry monitor and reusable as a stand-alone receiver.
- Contains its own UART receive datapath (synchronizer, bit timer, shift register) and a packet-framing FSM.

---
 rtl/telemetry_mon.sv | 179 +++++++++++++++++
 tb/tb_telemetry_mon.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_mon.sv
// eBike telemetry receiver: 8N1 UART front end plus a framing FSM that
// decodes AA 55 BATT CURR TORQUE packets into three 12-bit readings.
module telemetry_mon #(
    parameter int BAUD_DIV = 2604,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] BATT_TX,
    output logic [11:0] CURR_TX,
    output logic [11:0] TORQUE_TX,
    output logic        vld_TX,
    output logic        frm_err,
    output logic [7:0]  pkt_cnt
);

    localparam logic [11:0] LP_BAUD = 12'(BAUD_DIV);
    localparam logic [11:0] LP_HALF = 12'(HALF_DIV);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_SYNC1, P_SYNC2, P_PAYLOAD} pkt_state_t;

    uart_state_t r_ustate;
    pkt_state_t  r_pstate;

    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [11:0] r_timer;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_byte_rdy, r_stop_err;

    logic [2:0]  r_idx;
    logic [7:0]  r_shadow [0:4];
    logic [11:0] r_batt, r_curr, r_torque;
    logic        r_vld, r_ferr;
    logic [7:0]  r_pkt_cnt;

    logic w_fall, w_tick, w_hi_bad;

    // Synchronizer presets to the idle-high line level so reset never fakes a start bit.
    // NOTE: sequential state uses <= so every flop sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall   = r_rx_prev & ~r_rx_sync;
    assign w_tick   = (r_timer == 12'd1);
    // Even payload indices carry the hi byte, whose upper nibble must be zero.
    assign w_hi_bad = ~r_idx[0] & (r_shift[7:4] != 4'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ustate   <= U_IDLE;
            r_timer    <= 12'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte_rdy <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_byte_rdy <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_ustate)
                U_IDLE: begin
                    if (w_fall) begin
                        r_timer  <= LP_HALF;
                        r_ustate <= U_START;
                    end
                end
                U_START: begin
                    if (w_tick) begin
                        if (!r_rx_sync) begin
                            r_timer   <= LP_BAUD;
                            r_bit_cnt <= 3'd0;
                            r_ustate  <= U_DATA;
                        end else begin
                            r_ustate  <= U_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 12'd1;
                    end
                end
                U_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_timer <= LP_BAUD;
                        if (r_bit_cnt == 3'd7) r_ustate  <= U_STOP;
                        else                   r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_timer <= r_timer - 12'd1;
                    end
                end
                U_STOP: begin
                    if (w_tick) begin
                        if (r_rx_sync) r_byte_rdy <= 1'b1;
                        else           r_stop_err <= 1'b1;
                        r_ustate <= U_IDLE;
                    end else begin
                        r_timer <= r_timer - 12'd1;
                    end
                end
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    // NOTE: the shadow buffer has no reset; every entry is rewritten before a packet can commit.
    always_ff @(posedge clk) begin
        if (r_byte_rdy && r_pstate == P_PAYLOAD && r_idx < 3'd5)
            r_shadow[r_idx] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate  <= P_SYNC1;
            r_idx     <= 3'd0;
            r_batt    <= 12'd0;
            r_curr    <= 12'd0;
            r_torque  <= 12'd0;
            r_vld     <= 1'b0;
            r_ferr    <= 1'b0;
            r_pkt_cnt <= 8'd0;
        end else begin
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            if (r_stop_err) begin
                r_ferr   <= 1'b1;
                r_pstate <= P_SYNC1;
            end else if (r_byte_rdy) begin
                case (r_pstate)
                    P_SYNC1: begin
                        if (r_shift == 8'hAA) r_pstate <= P_SYNC2;
                    end
                    P_SYNC2: begin
                        if (r_shift == 8'h55) begin
                            r_pstate <= P_PAYLOAD;
                            r_idx    <= 3'd0;
                        end else if (r_shift != 8'hAA) begin
                            r_pstate <= P_SYNC1;
                        end
                    end
                    P_PAYLOAD: begin
                        if (w_hi_bad) begin
                            r_ferr   <= 1'b1;
                            r_pstate <= P_SYNC1;
                        end else if (r_idx == 3'd5) begin
                            // Last byte goes straight to the outputs; the rest come from the shadow.
                            r_batt    <= {r_shadow[0][3:0], r_shadow[1]};
                            r_curr    <= {r_shadow[2][3:0], r_shadow[3]};
                            r_torque  <= {r_shadow[4][3:0], r_shift};
                            r_vld     <= 1'b1;
                            r_pkt_cnt <= r_pkt_cnt + 8'd1;
                            r_pstate  <= P_SYNC1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    default: r_pstate <= P_SYNC1;
                endcase
            end
        end
    end

    assign BATT_TX   = r_batt;
    assign CURR_TX   = r_curr;
    assign TORQUE_TX = r_torque;
    assign vld_TX    = r_vld;
    assign frm_err   = r_ferr;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_telemetry_mon.sv
// Randomized scoreboard bench for telemetry_mon: a byte-level packet model
// queues expected vld/frm_err events, a monitor pops them as the DUT emits.
module tb_telemetry_mon;

    localparam int BAUD = 8;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [11:0] BATT_TX, CURR_TX, TORQUE_TX;
    logic        vld_TX, frm_err;
    logic [7:0]  pkt_cnt;

    telemetry_mon #(.BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .RX(RX),
        .BATT_TX(BATT_TX), .CURR_TX(CURR_TX), .TORQUE_TX(TORQUE_TX),
        .vld_TX(vld_TX), .frm_err(frm_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_vld;
        logic [11:0] batt, curr, torq;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  m_win[$];
    logic [11:0] m_batt = 0, m_curr = 0, m_torq = 0;
    int          m_good = 0;
    int          n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_ferr();
        ev_t e;
        e.is_vld = 1'b0; e.batt = '0; e.curr = '0; e.torq = '0; e.cnt = '0;
        exp_q.push_back(e);
    endfunction

    // Reference: rules applied to the byte stream, holding the candidate packet in a window.
    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        int  n;
        ev_t e;
        if (!stop_ok) begin
            push_ferr();
            m_win.delete();
            return;
        end
        n = m_win.size();
        if (n == 0) begin
            if (b == 8'hAA) m_win.push_back(b);
        end else if (n == 1) begin
            if (b == 8'h55) m_win.push_back(b);
            else if (b != 8'hAA) m_win.delete();
        end else if ((n % 2 == 0) && (b[7:4] != 4'h0)) begin
            push_ferr();
            m_win.delete();
        end else begin
            m_win.push_back(b);
            if (m_win.size() == 8) begin
                m_batt = {m_win[2][3:0], m_win[3]};
                m_curr = {m_win[4][3:0], m_win[5]};
                m_torq = {m_win[6][3:0], m_win[7]};
                m_good++;
                e.is_vld = 1'b1; e.batt = m_batt; e.curr = m_curr; e.torq = m_torq;
                e.cnt = 8'(m_good);
                exp_q.push_back(e);
                m_win.delete();
            end
        end
    endfunction

    task automatic drive(input logic lvl, input int n);
        RX = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive(1'b0, BAUD);
        for (int i = 0; i < 8; i++) drive(b[i], BAUD);
        drive(stop_ok, BAUD);
        drive(1'b1, GAP);
    endtask

    task automatic send_pkt(input logic [11:0] ba, input logic [11:0] cu, input logic [11:0] tq);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte({4'h0, ba[11:8]}, 1'b1);
        send_byte(ba[7:0], 1'b1);
        send_byte({4'h0, cu[11:8]}, 1'b1);
        send_byte(cu[7:0], 1'b1);
        send_byte({4'h0, tq[11:8]}, 1'b1);
        send_byte(tq[7:0], 1'b1);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_batt"}, BATT_TX, m_batt);
        check({tag, "_curr"}, CURR_TX, m_curr);
        check({tag, "_torq"}, TORQUE_TX, m_torq);
        check({tag, "_cnt"}, pkt_cnt, 8'(m_good));
    endtask

    task automatic send_random_pkt();
        logic [7:0]  b[8];
        logic [11:0] ba, cu, tq;
        int          r, bad_k;
        r  = $urandom_range(0, 15);
        ba = 12'($urandom); cu = 12'($urandom); tq = 12'($urandom);
        b[0] = 8'hAA; b[1] = 8'h55;
        b[2] = {4'h0, ba[11:8]}; b[3] = ba[7:0];
        b[4] = {4'h0, cu[11:8]}; b[5] = cu[7:0];
        b[6] = {4'h0, tq[11:8]}; b[7] = tq[7:0];
        if (r == 0) b[2 * $urandom_range(1, 3)][4] = 1'b1;
        if (r == 1) send_byte(8'($urandom), 1'b1);
        bad_k = (r == 2) ? $urandom_range(0, 7) : 8;
        for (int i = 0; i < 8; i++) send_byte(b[i], i != bad_k);
    endtask

    // Monitor: every vld_TX / frm_err pulse must match the next queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (vld_TX || frm_err)) begin
                if (vld_TX && frm_err) check("vld_and_ferr", 32'(vld_TX & frm_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", {30'd0, vld_TX, frm_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_kind", 32'(vld_TX), 32'(e.is_vld));
                    if (e.is_vld && vld_TX) begin
                        check("evt_batt", BATT_TX, e.batt);
                        check("evt_curr", CURR_TX, e.curr);
                        check("evt_torq", TORQUE_TX, e.torq);
                        check("evt_cnt", pkt_cnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outs("rst");
        check("rst_vld", vld_TX, 0);
        check("rst_ferr", frm_err, 0);
        rst = 1'b0;
        drive(1'b1, 20);

        // Basic packet
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h0B, 1); send_byte(8'h80, 1);
        send_byte(8'h01, 1); send_byte(8'h23, 1); send_byte(8'h07, 1); send_byte(8'hFF, 1);
        drive(1'b1, 10);
        check("t1_batt", BATT_TX, 12'hB80);
        check("t1_curr", CURR_TX, 12'h123);
        check("t1_torq", TORQUE_TX, 12'h7FF);
        check("t1_cnt", pkt_cnt, 8'd1);

        // Leading garbage before the sync pair
        send_byte(8'h12, 1); send_byte(8'hAA, 1); send_byte(8'hAA, 1); send_byte(8'h55, 1);
        send_byte(8'h00, 1); send_byte(8'h10, 1); send_byte(8'h00, 1); send_byte(8'h20, 1);
        send_byte(8'h00, 1); send_byte(8'h30, 1);
        drive(1'b1, 10);
        check("t2_batt", BATT_TX, 12'h010);
        check("t2_curr", CURR_TX, 12'h020);
        check("t2_torq", TORQUE_TX, 12'h030);

        // Bad stop bit on the 5th byte, then recovery
        send_pkt(12'h321, 12'h654, 12'h987);
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h01, 1); send_byte(8'h23, 1);
        send_byte(8'h00, 0); send_byte(8'h67, 1); send_byte(8'h00, 1); send_byte(8'h89, 1);
        drive(1'b1, 10);
        check("t3_hold_batt", BATT_TX, 12'h321);
        check_outs("t3_hold");
        send_pkt(12'hABC, 12'h0DE, 12'hF01);
        drive(1'b1, 10);
        check_outs("t3_next");

        // Non-zero hi nibble in BATT
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h1F, 1); send_byte(8'h00, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
        drive(1'b1, 10);
        check("t4_hold_batt", BATT_TX, 12'hABC);
        check_outs("t4_hold");

        // Short low glitch while idle
        drive(1'b0, 3);
        drive(1'b1, 30);
        send_pkt(12'h555, 12'hAAA, 12'h0F0);
        drive(1'b1, 10);
        check_outs("t5");

        // Reset in the middle of a packet
        send_byte(8'hAA, 1); send_byte(8'h55, 1); send_byte(8'h03, 1); send_byte(8'h21, 1);
        rst = 1'b1;
        m_win.delete();
        m_batt = 0; m_curr = 0; m_torq = 0; m_good = 0;
        drive(1'b1, 4);
        check_outs("t6_rst");
        rst = 1'b0;
        drive(1'b1, 10);
        send_pkt(12'h246, 12'h8AC, 12'hE02);
        drive(1'b1, 10);
        check_outs("t6");
        check("t6_cnt1", pkt_cnt, 8'd1);

        // Random traffic with occasional faults until the counter wraps
        while (m_good < 256) send_random_pkt();
        drive(1'b1, 20);
        check("wrap_cnt", pkt_cnt, 8'd0);
        check_outs("wrap");

        drive(1'b1, 50);
        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
